// File: rtl/alien_march_ctrl_pkg.sv
// Shared constants and types for the alien formation march sequencer.
// Contents: formation geometry (column count, pitch, sprite width),
// the frame-interval counter width and the march FSM state type.
// Optional feature macro used by the importing files: ALIEN_MARCH_SPEEDUP_EN.
package alien_pkg;

  localparam int NUM_COLS  = 11;
  localparam int COL_PITCH = 40;
  localparam int ALIEN_W   = 31;

  // Must hold BASE_FRAMES (largest interval) and a column index / count up to NUM_COLS.
  localparam int INTV_W    = 4;
  localparam int COL_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_APPLY,
    ST_LANDED
  } march_state_t;

endpackage

// File: rtl/alien_march_ctrl_alive_edge_finder.sv
// alive_edge_finder: combinational scan of the live-column mask.
// Ports:
//   alive_cols  in  NUM_COLS   bit i = column i still has a live alien
//   left_col    out COL_IDX_W  lowest set column (0 when mask is empty)
//   right_col   out COL_IDX_W  highest set column (0 when mask is empty)
//   alive_cnt   out COL_IDX_W  number of live columns; only present when
//                              ALIEN_MARCH_SPEEDUP_EN is defined
module alive_edge_finder
  import alien_pkg::*;
(
  input  logic [NUM_COLS-1:0]  alive_cols,
  output logic [COL_IDX_W-1:0] left_col,
  output logic [COL_IDX_W-1:0] right_col
`ifdef ALIEN_MARCH_SPEEDUP_EN
  ,
  output logic [COL_IDX_W-1:0] alive_cnt
`endif
);

  // Scan from the far end so the last hit wins: downwards for the lowest
  // set column, upwards for the highest.
  always_comb begin
    left_col  = '0;
    right_col = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (alive_cols[i]) left_col = COL_IDX_W'(i);
    end
    for (int i = 0; i < NUM_COLS; i++) begin
      if (alive_cols[i]) right_col = COL_IDX_W'(i);
    end
  end

`ifdef ALIEN_MARCH_SPEEDUP_EN
  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      alive_cnt = alive_cnt + COL_IDX_W'(alive_cols[i]);
    end
  end
`endif

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: owns the alien formation origin and marches it on frame
// ticks, stepping sideways, dropping and reversing at the screen edges, and
// flagging when the formation reaches the landing line.
// Optional feature: ALIEN_MARCH_SPEEDUP_EN shortens the step interval by two
// frames per dead column (never below one frame).
// Ports:
//   clk_pix     in   1   pixel clock
//   rst_n       in   1   synchronous active-low reset
//   frame       in   1   one-cycle pulse per video frame
//   enable      in   1   march allowed; low freezes the frame counter
//   wave_start  in   1   one-cycle pulse, reinitialise formation
//   speed       in   2   step interval = BASE_FRAMES >> speed
//   alive_cols  in   11  live-column mask
//   ax          out  10  formation origin X
//   ay          out  9   formation origin Y
//   dir_left    out  1   0 = moving right, 1 = moving left
//   anim_frame  out  1   sprite animation select
//   step_pulse  out  1   one-cycle pulse when ax/ay update
//   landed      out  1   sticky landing flag
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | after reset, waiting for the first enable
// ST_WAIT   | counting qualifying frames until the step interval elapses
// ST_CHECK  | capture lowest/highest live column
// ST_APPLY  | decide step vs drop vs landing and update the origin
// ST_LANDED | formation hit the landing line; frozen until wave_start/reset
module alien_march_ctrl
  import alien_pkg::*;
#(
  parameter int X_START     = 135,
  parameter int Y_START     = 85,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 8,
  parameter int X_MIN       = 40,
  parameter int X_MAX       = 600,
  parameter int Y_LAND      = 440,
  parameter int FORM_H      = 158,
  parameter int BASE_FRAMES = 8
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic                frame,
  input  logic                enable,
  input  logic                wave_start,
  input  logic [1:0]          speed,
  input  logic [NUM_COLS-1:0] alive_cols,
  output logic [9:0]          ax,
  output logic [8:0]          ay,
  output logic                dir_left,
  output logic                anim_frame,
  output logic                step_pulse,
  output logic                landed
);

  march_state_t         state_q, state_d;
  logic [9:0]           ax_q, ax_d;
  logic [8:0]           ay_q, ay_d;
  logic                 dir_left_q, dir_left_d;
  logic                 anim_frame_q, anim_frame_d;
  logic                 step_pulse_q, step_pulse_d;
  logic                 landed_q, landed_d;
  logic [INTV_W-1:0]    fcnt_q, fcnt_d;
  logic [COL_IDX_W-1:0] l_q, l_d;
  logic [COL_IDX_W-1:0] r_q, r_d;

  logic [COL_IDX_W-1:0] left_col, right_col;
  logic [INTV_W-1:0]    interval;
  logic [INTV_W:0]      fcnt_inc;
  logic [10:0]          ax_ext, right_edge, left_edge, ay_drop;
  logic                 drop_right, drop_left, do_drop, do_land;

`ifdef ALIEN_MARCH_SPEEDUP_EN
  logic [COL_IDX_W-1:0] alive_cnt;
  logic [5:0]           base_ext, dead_x2;

  alive_edge_finder u_edge (
    .alive_cols (alive_cols),
    .left_col   (left_col),
    .right_col  (right_col),
    .alive_cnt  (alive_cnt)
  );

  // Subtraction is done in 6 bits so a large dead count clamps to 1
  // instead of wrapping.
  always_comb begin
    base_ext = 6'(BASE_FRAMES >> speed);
    dead_x2  = {(5'(NUM_COLS) - {1'b0, alive_cnt}), 1'b0};
    interval = (base_ext > dead_x2) ? INTV_W'(base_ext - dead_x2) : INTV_W'(1);
  end
`else
  alive_edge_finder u_edge (
    .alive_cols (alive_cols),
    .left_col   (left_col),
    .right_col  (right_col)
  );

  always_comb begin
    interval = INTV_W'(BASE_FRAMES >> speed);
  end
`endif

  // fcnt >= interval-1 rewritten as fcnt+1 >= interval, so a zero interval
  // cannot underflow. The >= also makes a shrinking interval step at once.
  assign fcnt_inc = {1'b0, fcnt_q} + 1'b1;

  // Edge decision in 11 bits: worst case 1023 + 400 + 33 stays in range.
  always_comb begin
    ax_ext     = {1'b0, ax_q};
    right_edge = ax_ext + 11'(COL_PITCH) * {7'b0, r_q} + 11'(ALIEN_W + STEP_X);
    left_edge  = ax_ext + 11'(COL_PITCH) * {7'b0, l_q};
    drop_right = right_edge > 11'(X_MAX);
    drop_left  = (ax_ext < 11'(STEP_X)) || (left_edge < 11'(X_MIN + STEP_X));
    do_drop    = dir_left_q ? drop_left : drop_right;
    ay_drop    = {2'b0, ay_q} + 11'(STEP_Y);
    do_land    = (ay_drop + 11'(FORM_H)) > 11'(Y_LAND);
  end

  always_comb begin
    state_d      = state_q;
    ax_d         = ax_q;
    ay_d         = ay_q;
    dir_left_d   = dir_left_q;
    anim_frame_d = anim_frame_q;
    step_pulse_d = 1'b0;
    landed_d     = landed_q;
    fcnt_d       = fcnt_q;
    l_d          = l_q;
    r_d          = r_q;

    if (wave_start) begin
      state_d      = ST_WAIT;
      ax_d         = 10'(X_START);
      ay_d         = 9'(Y_START);
      dir_left_d   = 1'b0;
      anim_frame_d = 1'b0;
      landed_d     = 1'b0;
      fcnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (frame && enable && (alive_cols != '0)) begin
            if (fcnt_inc >= {1'b0, interval}) begin
              fcnt_d  = '0;
              state_d = ST_CHECK;
            end else begin
              fcnt_d = fcnt_inc[INTV_W-1:0];
            end
          end
        end
        ST_CHECK: begin
          l_d     = left_col;
          r_d     = right_col;
          state_d = ST_APPLY;
        end
        ST_APPLY: begin
          if (do_drop && do_land) begin
            // Landing freezes every output except the flag itself.
            landed_d = 1'b1;
            state_d  = ST_LANDED;
          end else begin
            if (do_drop) begin
              ay_d       = ay_drop[8:0];
              dir_left_d = ~dir_left_q;
            end else if (dir_left_q) begin
              ax_d = ax_q - 10'(STEP_X);
            end else begin
              ax_d = ax_q + 10'(STEP_X);
            end
            anim_frame_d = ~anim_frame_q;
            step_pulse_d = 1'b1;
            state_d      = ST_WAIT;
          end
        end
        ST_LANDED: begin
          state_d = ST_LANDED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ax_q         <= 10'(X_START);
      ay_q         <= 9'(Y_START);
      dir_left_q   <= 1'b0;
      anim_frame_q <= 1'b0;
      step_pulse_q <= 1'b0;
      landed_q     <= 1'b0;
      fcnt_q       <= '0;
      l_q          <= '0;
      r_q          <= '0;
    end else begin
      state_q      <= state_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      dir_left_q   <= dir_left_d;
      anim_frame_q <= anim_frame_d;
      step_pulse_q <= step_pulse_d;
      landed_q     <= landed_d;
      fcnt_q       <= fcnt_d;
      l_q          <= l_d;
      r_q          <= r_d;
    end
  end

  assign ax         = ax_q;
  assign ay         = ay_q;
  assign dir_left   = dir_left_q;
  assign anim_frame = anim_frame_q;
  assign step_pulse = step_pulse_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Testbench for alien_march_ctrl. Three instances share all inputs:
//   u_dut  default parameters
//   u_even X_START=134, so the leftward march passes 44, 42, 40
//   u_land Y_START=270: first drop reaches 436 (no landing), second lands
// The speed-up check is compiled only with ALIEN_MARCH_SPEEDUP_EN.
module tb_alien_march_ctrl;

  logic        clk_pix = 1'b0;
  logic        rst_n, frame, enable, wave_start;
  logic [1:0]  speed;
  logic [10:0] alive_cols;

  logic [9:0] d_ax, e_ax, l_ax;
  logic [8:0] d_ay, e_ay, l_ay;
  logic       d_dir, e_dir, l_dir;
  logic       d_anim, e_anim, l_anim;
  logic       d_step, e_step, l_step;
  logic       d_land, e_land, l_land;

  always #5 clk_pix = ~clk_pix;

  alien_march_ctrl u_dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .enable(enable),
    .wave_start(wave_start), .speed(speed), .alive_cols(alive_cols),
    .ax(d_ax), .ay(d_ay), .dir_left(d_dir), .anim_frame(d_anim),
    .step_pulse(d_step), .landed(d_land)
  );

  alien_march_ctrl #(.X_START(134)) u_even (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .enable(enable),
    .wave_start(wave_start), .speed(speed), .alive_cols(alive_cols),
    .ax(e_ax), .ay(e_ay), .dir_left(e_dir), .anim_frame(e_anim),
    .step_pulse(e_step), .landed(e_land)
  );

  alien_march_ctrl #(.Y_START(270)) u_land (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .enable(enable),
    .wave_start(wave_start), .speed(speed), .alive_cols(alive_cols),
    .ax(l_ax), .ay(l_ay), .dir_left(l_dir), .anim_frame(l_anim),
    .step_pulse(l_step), .landed(l_land)
  );

  typedef struct {
    int          n;
    logic [10:0] alive;
    int          ax, ay, dir, anim;
    int          eax, eay, edir;
    int          lax, lay, lland;
  } vec_t;

  vec_t vt[9];
  int   total = 0;
  int   bad   = 0;
  int   sp_cnt = 0;
  int   sp0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
    sp_cnt += int'(d_step);
  endtask

  // One frame pulse followed by enough idle cycles for a full step to finish.
  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    vt[0] = '{1,  11'h7FF, 139, 85,  0, 0, 138, 85,  0, 139, 270, 0};
    vt[1] = '{14, 11'h7FF, 167, 85,  0, 0, 166, 85,  0, 167, 270, 0};
    vt[2] = '{1,  11'h7FF, 169, 85,  0, 1, 168, 85,  0, 169, 270, 0};
    vt[3] = '{1,  11'h7FF, 169, 93,  1, 0, 168, 93,  1, 169, 278, 0};
    vt[4] = '{62, 11'h001, 45,  93,  1, 0, 44,  93,  1, 45,  278, 0};
    vt[5] = '{1,  11'h001, 43,  93,  1, 1, 42,  93,  1, 43,  278, 0};
    vt[6] = '{1,  11'h001, 41,  93,  1, 0, 40,  93,  1, 41,  278, 0};
    vt[7] = '{1,  11'h001, 41,  101, 0, 1, 40,  101, 0, 41,  278, 1};
    vt[8] = '{3,  11'h001, 47,  101, 0, 0, 46,  101, 0, 41,  278, 1};

    rst_n = 1'b0; frame = 1'b0; enable = 1'b0; wave_start = 1'b0;
    speed = 2'd0; alive_cols = 11'h7FF;
    tick(); tick();
    chk("rst_ax", int'(d_ax), 135);
    chk("rst_ay", int'(d_ay), 85);
    chk("rst_dir", int'(d_dir), 0);
    chk("rst_anim", int'(d_anim), 0);
    chk("rst_step", int'(d_step), 0);
    chk("rst_landed", int'(d_land), 0);

    rst_n = 1'b1; enable = 1'b1;
    tick();
    repeat (7) pulse_frame();
    chk("pre_step_ax", int'(d_ax), 135);
    chk("pre_step_pulses", sp_cnt, 0);

    // Eighth frame: step_pulse must appear exactly two edges later.
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("lat_e0_step", int'(d_step), 0);
    tick();
    chk("lat_e1_step", int'(d_step), 0);
    chk("lat_e1_ax", int'(d_ax), 135);
    tick();
    chk("lat_e2_step", int'(d_step), 1);
    chk("lat_e2_ax", int'(d_ax), 137);
    chk("lat_e2_ay", int'(d_ay), 85);
    chk("lat_e2_anim", int'(d_anim), 1);
    tick();
    chk("lat_e3_step", int'(d_step), 0);
    tick();

    speed = 2'd3;
    for (int r = 0; r < 9; r++) begin
      alive_cols = vt[r].alive;
      repeat (vt[r].n) pulse_frame();
      chk($sformatf("v%0d_ax", r), int'(d_ax), vt[r].ax);
      chk($sformatf("v%0d_ay", r), int'(d_ay), vt[r].ay);
      chk($sformatf("v%0d_dir", r), int'(d_dir), vt[r].dir);
      chk($sformatf("v%0d_anim", r), int'(d_anim), vt[r].anim);
      chk($sformatf("v%0d_even_ax", r), int'(e_ax), vt[r].eax);
      chk($sformatf("v%0d_even_ay", r), int'(e_ay), vt[r].eay);
      chk($sformatf("v%0d_even_dir", r), int'(e_dir), vt[r].edir);
      chk($sformatf("v%0d_land_ax", r), int'(l_ax), vt[r].lax);
      chk($sformatf("v%0d_land_ay", r), int'(l_ay), vt[r].lay);
      chk($sformatf("v%0d_land_flag", r), int'(l_land), vt[r].lland);
    end

    wave_start = 1'b1;
    tick();
    wave_start = 1'b0;
    chk("ws_ax", int'(d_ax), 135);
    chk("ws_ay", int'(d_ay), 85);
    chk("ws_dir", int'(d_dir), 0);
    chk("ws_anim", int'(d_anim), 0);
    chk("ws_land_ax", int'(l_ax), 135);
    chk("ws_land_ay", int'(l_ay), 270);
    chk("ws_land_flag", int'(l_land), 0);

    // Frame counter hold: 3 counted, 40 ignored, then 4 more counted
    // without a step and the fifth steps.
    speed = 2'd0; alive_cols = 11'h7FF;
    repeat (3) pulse_frame();
    sp0 = sp_cnt;
    enable = 1'b0;
    repeat (20) pulse_frame();
    enable = 1'b1; alive_cols = 11'h000;
    repeat (20) pulse_frame();
    chk("freeze_pulses", sp_cnt, sp0);
    chk("freeze_ax", int'(d_ax), 135);
    alive_cols = 11'h7FF;
    repeat (4) pulse_frame();
    chk("hold_ax_4", int'(d_ax), 135);
    pulse_frame();
    chk("hold_ax_5", int'(d_ax), 137);
    chk("hold_pulses", sp_cnt, sp0 + 1);

    // Shrink interval below the current count: next frame steps.
    repeat (5) pulse_frame();
    chk("shrink_pre_ax", int'(d_ax), 137);
    speed = 2'd2;
    pulse_frame();
    chk("shrink_ax", int'(d_ax), 139);

    // Reset asserted while in APPLY wins over the step.
    speed = 2'd3;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstapply_ax", int'(d_ax), 135);
    chk("rstapply_ay", int'(d_ay), 85);
    chk("rstapply_step", int'(d_step), 0);
    chk("rstapply_anim", int'(d_anim), 0);
    chk("rstapply_dir", int'(d_dir), 0);
    rst_n = 1'b1;
    tick();

`ifdef ALIEN_MARCH_SPEEDUP_EN
    speed = 2'd0; alive_cols = 11'h007;
    repeat (3) pulse_frame();
    chk("speedup_ax", int'(d_ax), 141);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
